apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: WAIT-state cycle limit before abort; legal range 2..255.
REQ-002 hclk  in  1  sole clock; all state updates on the rising edge.
REQ-003 hresetn  in  1  asynchronous, active-low reset.
REQ-004 req0, req1  in  1 each  requester x transfer request; level-sensitive.
REQ-005 wr0, wr1  in  1 each  requester x direction: 1 = write, 0 = read.
REQ-006 addr0, addr1  in  32 each  requester x address.
REQ-007 wdata0, wdata1  in  32 each  requester x write data.
REQ-008 gnt0, gnt1  out  1 each  one-cycle pulse: request x captured.
REQ-009 done0, done1  out  1 each  one-cycle pulse: transfer x complete.
REQ-010 err0, err1  out  1 each  one-cycle pulse, coincident with done_x: transfer x aborted.
REQ-011 rdata  out  32  read data; valid in the done_x cycle.
REQ-012 m_valid  out  1  one-cycle transfer strobe to the APB controller.
REQ-013 m_hwrite, m_haddr, m_hwdata  out  1/32/32  latched direction, address and data; held stable from m_valid until done.
REQ-014 m_done  in  1  controller pulse: APB access phase complete.
REQ-015 pr_data  in  32  APB read data; sampled when m_done=1.

Function
REQ-016 FSM states: ST_IDLE, ST_ISSUE, ST_WAIT; all outputs are registered.
REQ-017 ST_IDLE, at least one req high at edge N: arbitrate, latch wr/addr/wdata of the winner, go ST_ISSUE.
- gnt_x=1 and m_valid=1 during cycle N+1 only.
REQ-018 Arbitration is round-robin.
- Both req high: the requester not served last wins.
- Only one req high: that requester wins, regardless of history.
REQ-019 The last-served pointer updates on completion, including abort; it is not updated at grant.
REQ-020 ST_ISSUE always moves to ST_WAIT after one cycle.
REQ-021 ST_ISSUE or ST_WAIT with m_done=1 at edge M:
- rdata <= pr_data on reads; rdata holds its previous value on writes.
- done_x=1 during cycle M+1; state returns to ST_IDLE.
REQ-022 Back-to-back throughput: a request seen at edge M+1 is granted in cycle M+2, giving a minimum 3 cycles between m_valid strobes.
REQ-023 req_x is ignored once granted; a requester that drops req after gnt still receives done_x.
REQ-024 m_done in ST_IDLE is ignored and causes no output change.
REQ-025 m_hwrite/m_haddr/m_hwdata change only on the grant edge.
REQ-026 gnt0/gnt1, done0/done1 and err0/err1 are each mutually exclusive per cycle.

Reset
REQ-027 hresetn=0 immediately clears all state, with no clock needed:
- state=ST_IDLE; pointer=requester 1 last, so requester 0 wins the first tie.
- All outputs 0; rdata=0.
REQ-028 Reset mid-transfer abandons the transfer; no done_x or err_x is produced afterward.
REQ-029 The first grant can occur in the cycle after the first rising edge following reset release.

Configuration
REQ-030 Macro APB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ST_WAIT and increments each ST_WAIT cycle. When it reaches TIMEOUT without m_done, done_x=1, err_x=1, rdata=32'h0 in the next cycle, and state goes to ST_IDLE. m_done on the same edge as expiry wins; it is a normal completion with err_x=0.
- Undefined: no counter logic; ST_WAIT waits indefinitely; err0/err1 are tied to 0.

Verification
REQ-031 req0=1 rd addr0=32'h4000_0010; m_done 3 cycles after m_valid with pr_data=32'hA5A5_0001 -> gnt0 in cycle 1; done0 in the cycle after m_done; rdata=32'hA5A5_0001.
REQ-032 req0=req1=1 held, write, 4 transfers -> grant order 0,1,0,1; m_haddr tracks the winner; no m_valid overlap.
REQ-033 Only req1 high, repeated 3 times -> req1 granted each time; then req0 and req1 tied -> req0 granted.
REQ-034 hresetn low during ST_WAIT, m_done pulsed afterward -> all outputs 0; no done_x; first post-reset tie granted to req0.
REQ-035 With APB_ARB_TIMEOUT_EN and TIMEOUT=16, m_done never sent -> done1=err1=1 exactly 16 cycles into ST_WAIT; rdata=0; a late m_done is ignored.
REQ-036 Write with wr0=1, wdata0=32'hCAFE_F00D, req0 dropped after gnt0 -> m_hwdata=32'hCAFE_F00D stable until done0; done0 still pulses; rdata unchanged.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Two-requester round-robin arbiter in front of an APB controller. A winning
// request is latched (direction/address/data), strobed to the controller with
// a one-cycle m_valid, and the requester is told of completion with a
// one-cycle done_x pulse. Read data is returned on rdata in the done cycle.
//
// Ports
//   hclk, hresetn               clock, asynchronous active-low reset
//   req0/1, wr0/1               per-requester request level and direction
//   addr0/1, wdata0/1           per-requester address and write data
//   gnt0/1                      one-cycle pulse: request captured
//   done0/1, err0/1             one-cycle pulses: transfer complete / aborted
//   rdata                       read data, valid in the done cycle
//   m_valid                     one-cycle transfer strobe to the controller
//   m_hwrite/m_haddr/m_hwdata   latched transfer, stable from m_valid to done
//   m_done, pr_data             controller completion pulse and read data
//
// Configuration
//   APB_ARB_TIMEOUT_EN  when defined, a transfer left in the wait state for
//                       TIMEOUT cycles without m_done is aborted (done+err,
//                       rdata=0). When undefined, err0/err1 are constant 0.
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        m_valid,
  output logic        m_hwrite,
  output logic [31:0] m_haddr,
  output logic [31:0] m_hwdata,
  input  logic        m_done,
  input  logic [31:0] pr_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // requester currently being served
  logic        last_q, last_d;     // requester served most recently
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        m_valid_q, m_valid_d;
  logic        m_hwrite_q, m_hwrite_d;
  logic [31:0] m_haddr_q, m_haddr_d;
  logic [31:0] m_hwdata_q, m_hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        win;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err0_q, err0_d, err1_q, err1_d;
`else
  // Keeps TIMEOUT referenced when the timeout logic is compiled out.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    m_valid_d  = 1'b0;
    m_hwrite_d = m_hwrite_q;
    m_haddr_d  = m_haddr_q;
    m_hwdata_d = m_hwdata_q;
    rdata_d    = rdata_q;
    win        = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; otherwise the lone
          // requester wins regardless of history.
          win        = (req0 && req1) ? ~last_q : req1;
          owner_d    = win;
          gnt0_d     = ~win;
          gnt1_d     = win;
          m_valid_d  = 1'b1;
          m_hwrite_d = win ? wr1    : wr0;
          m_haddr_d  = win ? addr1  : addr0;
          m_hwdata_d = win ? wdata1 : wdata0;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (m_done) begin
          // Completion takes priority over a timeout expiring on the same edge.
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (!m_hwrite_q) rdata_d = pr_data;
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
`ifdef APB_ARB_TIMEOUT_EN
          // cnt_q counts completed wait cycles; this edge ends wait cycle
          // cnt_q+1, so TO_LAST marks the TIMEOUT-th one.
          if (cnt_q == TO_LAST) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            err0_d  = ~owner_q;
            err1_d  = owner_q;
            rdata_d = '0;
            last_d  = owner_q;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer registers are reset too: every output, rdata included, must read
  // 0 straight out of reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;   // requester 0 wins the first tie
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_hwrite_q <= 1'b0;
      m_haddr_q  <= '0;
      m_hwdata_q <= '0;
      rdata_q    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      m_valid_q  <= m_valid_d;
      m_hwrite_q <= m_hwrite_d;
      m_haddr_q  <= m_haddr_d;
      m_hwdata_q <= m_hwdata_d;
      rdata_q    <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
`endif
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign m_valid  = m_valid_q;
  assign m_hwrite = m_hwrite_q;
  assign m_haddr  = m_haddr_q;
  assign m_hwdata = m_hwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign err0     = err0_q;
  assign err1     = err1_q;
`else
  assign err0     = 1'b0;
  assign err1     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed testbench for apb_req_arbiter. Inputs are driven 1 ns after the
// rising edge of hclk and outputs are checked at that same point, well away
// from the next active edge. The timeout scenario is compiled in only when
// APB_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

  logic        hclk;
  logic        hresetn;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        m_valid, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic        m_done;
  logic [31:0] pr_data;

  int n_tests = 0;
  int n_fail  = 0;

  apb_req_arbiter #(.TIMEOUT(16)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .req0     (req0),
    .req1     (req1),
    .wr0      (wr0),
    .wr1      (wr1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .err0     (err0),
    .err1     (err1),
    .rdata    (rdata),
    .m_valid  (m_valid),
    .m_hwrite (m_hwrite),
    .m_haddr  (m_haddr),
    .m_hwdata (m_hwdata),
    .m_done   (m_done),
    .pr_data  (pr_data)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (n_tests=%0d)", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  // Every output must be zero (reset state).
  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},     gnt0,     32'd0);
    check({tag, "_gnt1"},     gnt1,     32'd0);
    check({tag, "_done0"},    done0,    32'd0);
    check({tag, "_done1"},    done1,    32'd0);
    check({tag, "_err0"},     err0,     32'd0);
    check({tag, "_err1"},     err1,     32'd0);
    check({tag, "_m_valid"},  m_valid,  32'd0);
    check({tag, "_m_hwrite"}, m_hwrite, 32'd0);
    check({tag, "_m_haddr"},  m_haddr,  32'd0);
    check({tag, "_m_hwdata"}, m_hwdata, 32'd0);
    check({tag, "_rdata"},    rdata,    32'd0);
  endtask

  // Advance until m_valid is seen; n = cycles taken, -1 if the bound expires.
  task automatic wait_mvalid(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (m_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // From the m_valid cycle: one wait cycle, then m_done; check the done pulse.
  task automatic complete(input logic who, input string tag);
    cyc();
    check({tag, "_mvalid_lo"}, m_valid, 32'd0);
    m_done = 1'b1;
    cyc();
    m_done = 1'b0;
    check({tag, "_done0"}, done0, {31'd0, ~who});
    check({tag, "_done1"}, done1, {31'd0, who});
    check({tag, "_err0"},  err0,  32'd0);
    check({tag, "_err1"},  err1,  32'd0);
  endtask

  initial begin
    int n;
    logic exp1;
    logic [31:0] addr_tab [2];
    logic [31:0] data_tab [2];
    addr_tab[0] = 32'h0000_0100;
    addr_tab[1] = 32'h0000_0200;
    data_tab[0] = 32'hD000_0000;
    data_tab[1] = 32'hD111_1111;

    hresetn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    m_done = 1'b0; pr_data = '0;

    // Reset state.
    cyc();
    cyc();
    check_all_zero("rst");

    // Single read from requester 0, m_done three cycles after m_valid.
    hresetn = 1'b1;
    req0  = 1'b1;
    wr0   = 1'b0;
    addr0 = 32'h4000_0010;
    wait_mvalid(n);
    check("rd_first_grant_lat", n, 32'd1);
    check("rd_gnt0",     gnt0,     32'd1);
    check("rd_gnt1",     gnt1,     32'd0);
    check("rd_haddr",    m_haddr,  32'h4000_0010);
    check("rd_hwrite",   m_hwrite, 32'd0);
    req0 = 1'b0;
    cyc();
    check("rd_mvalid_pulse", m_valid, 32'd0);
    check("rd_gnt0_pulse",   gnt0,    32'd0);
    cyc();
    cyc();
    m_done  = 1'b1;
    pr_data = 32'hA5A5_0001;
    cyc();
    m_done  = 1'b0;
    pr_data = 32'h0;
    check("rd_done0", done0, 32'd1);
    check("rd_done1", done1, 32'd0);
    check("rd_rdata", rdata, 32'hA5A5_0001);
    cyc();
    check("rd_done0_pulse", done0, 32'd0);

    // Write from requester 0, which drops req and changes its inputs after gnt.
    req0   = 1'b1;
    wr0    = 1'b1;
    addr0  = 32'h4000_0020;
    wdata0 = 32'hCAFE_F00D;
    wait_mvalid(n);
    check("wr_gnt0",   gnt0,     32'd1);
    check("wr_hwrite", m_hwrite, 32'd1);
    check("wr_hwdata", m_hwdata, 32'hCAFE_F00D);
    req0   = 1'b0;
    wr0    = 1'b0;
    addr0  = 32'h0;
    wdata0 = 32'hDEAD_0000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("wr_hwdata_hold", m_hwdata, 32'hCAFE_F00D);
      check("wr_haddr_hold",  m_haddr,  32'h4000_0020);
      check("wr_hwrite_hold", m_hwrite, 32'd1);
      check("wr_no_early_done", done0, 32'd0);
    end
    m_done  = 1'b1;
    pr_data = 32'h1234_5678;
    cyc();
    m_done  = 1'b0;
    check("wr_done0",        done0,    32'd1);
    check("wr_rdata_kept",   rdata,    32'hA5A5_0001);
    check("wr_hwdata_final", m_hwdata, 32'hCAFE_F00D);

    // Stray m_done while idle.
    m_done = 1'b1;
    cyc();
    m_done = 1'b0;
    cyc();
    check("idle_mdone_done0", done0,   32'd0);
    check("idle_mdone_done1", done1,   32'd0);
    check("idle_mdone_valid", m_valid, 32'd0);
    check("idle_mdone_rdata", rdata,   32'hA5A5_0001);

    // Reset during the wait state. Requester 0 was served last, so without
    // reset a tie would go to requester 1.
    req0  = 1'b1;
    wr0   = 1'b0;
    addr0 = 32'h4000_0030;
    wait_mvalid(n);
    check("rw_gnt0", gnt0, 32'd1);
    req0 = 1'b0;
    cyc();
    cyc();
    #2 hresetn = 1'b0;
    #1;
    check_all_zero("rst_async");
    cyc();
    hresetn = 1'b1;
    m_done  = 1'b1;
    pr_data = 32'hFFFF_FFFF;
    cyc();
    m_done  = 1'b0;
    check("rst_late_done0", done0, 32'd0);
    check("rst_late_done1", done1, 32'd0);
    check("rst_late_rdata", rdata, 32'd0);
    cyc();
    check("rst_late_done0_b", done0, 32'd0);

    // Both requesters held: writes alternate 0,1,0,1 with back-to-back grants.
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1;
    addr0 = addr_tab[0]; addr1 = addr_tab[1];
    wdata0 = data_tab[0]; wdata1 = data_tab[1];
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2) == 1;
      wait_mvalid(n);
      check("rr_grant_lat", n, 32'd1);
      check("rr_gnt0",   gnt0,     {31'd0, ~exp1});
      check("rr_gnt1",   gnt1,     {31'd0, exp1});
      check("rr_haddr",  m_haddr,  addr_tab[exp1]);
      check("rr_hwdata", m_hwdata, data_tab[exp1]);
      complete(exp1, "rr");
    end

    // Requester 1 alone three times (reads), then a tie goes to requester 0.
    req0 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    pr_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      wait_mvalid(n);
      check("solo_gnt1", gnt1, 32'd1);
      check("solo_gnt0", gnt0, 32'd0);
      complete(1'b1, "solo");
      if (i == 2) req0 = 1'b1;
    end
    check("solo_rdata", rdata, 32'h5555_AAAA);
    wait_mvalid(n);
    check("tie_gnt0", gnt0, 32'd1);
    check("tie_gnt1", gnt1, 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    complete(1'b0, "tie");

`ifdef APB_ARB_TIMEOUT_EN
    // Requester 1 read never completed by the controller.
    req1 = 1'b1;
    wr1  = 1'b0;
    wait_mvalid(n);
    check("to_gnt1", gnt1, 32'd1);
    req1 = 1'b0;
    n = -1;
    for (int j = 1; j <= 40; j++) begin
      cyc();
      if (done1) begin
        n = j;
        break;
      end
    end
    // m_valid cycle, 16 wait cycles, then the abort pulse.
    check("to_done_cycle", n, 32'd17);
    check("to_err1",  err1,  32'd1);
    check("to_err0",  err0,  32'd0);
    check("to_done0", done0, 32'd0);
    check("to_rdata", rdata, 32'd0);
    m_done = 1'b1;
    cyc();
    m_done = 1'b0;
    check("to_late_done1", done1, 32'd0);
    check("to_late_err1",  err1,  32'd0);
    check("to_late_rdata", rdata, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
